uart_rx_error_check: RTL and testbench

- Checks one received UART frame for framing and parity errors.
- Sits in the UART receive path, after the deserializer (which supplies data, start, stop and parity bits plus a frame-done strobe) and before the APB status register.
- Produces a registered 3-bit error vector, updated once per received frame.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_parity_gen.sv | 55 +++++
 rtl/uart_rx_error_check.sv | 73 +++++++
 tb/tb_uart_rx_error_check.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: parity-mode encodings and the bit
//               positions of the receive error vector.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

   // Parity-mode encodings carried on parity_type
   localparam logic [1:0] PAR_NONE0 = 2'b00;
   localparam logic [1:0] PAR_ODD   = 2'b01;
   localparam logic [1:0] PAR_EVEN  = 2'b10;
   localparam logic [1:0] PAR_NONE1 = 2'b11;

   // Bit positions inside the 3-bit receive error vector
   localparam int unsigned ERR_PARITY = 0;
   localparam int unsigned ERR_START  = 1;
   localparam int unsigned ERR_STOP   = 2;
   localparam int unsigned ERR_WIDTH  = 3;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_parity_gen.sv
`default_nettype none
// ============================================================================
// Module      : uart_parity_gen
// Description : Purely combinational parity generator. Given a payload and a
//               parity mode it returns the parity bit a correct frame would
//               carry, plus a flag saying whether parity is in use at all.
//               Shared between the receive checker and the transmit path.
// Ports       :
//    data        in   DATA_WIDTH  payload bits
//    parity_type in   2           00/11 none, 01 odd, 10 even
//    parity_out  out  1           expected parity bit (0 when disabled)
//    parity_en   out  1           1 when the mode carries a parity bit
// Revision    : 1.0 - initial release
// ============================================================================
module uart_parity_gen
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] data,
   input  logic [1:0]            parity_type,
   output logic                  parity_out,
   output logic                  parity_en
);

   logic data_xor;

   assign data_xor = ^data;

   always_comb begin
      parity_out = 1'b0;
      parity_en  = 1'b0;
      case (parity_type)
         PAR_EVEN: begin
            // Even mode: parity makes the total count of ones even
            parity_out = data_xor;
            parity_en  = 1'b1;
         end
         PAR_ODD: begin
            parity_out = ~data_xor;
            parity_en  = 1'b1;
         end
         PAR_NONE0, PAR_NONE1: begin
            parity_out = 1'b0;
            parity_en  = 1'b0;
         end
         default: begin
            parity_out = 1'b0;
            parity_en  = 1'b0;
         end
      endcase
   end

endmodule : uart_parity_gen
`default_nettype wire

// File: rtl/uart_rx_error_check.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_error_check
// Description : Checks one received UART frame for start, stop and parity
//               errors and registers a 3-bit error vector. Every cycle the
//               deserializer strobe is high the frame is re-evaluated; with
//               the strobe low the vector holds and the valid pulse drops.
// Ports       :
//    clock          in   1           system clock, rising edge
//    reset          in   1           synchronous active-high reset
//    recieved_flag  in   1           frame fields valid this cycle
//    parity_bit     in   1           received parity bit
//    start_bit      in   1           received start bit (0 expected)
//    stop_bit       in   1           received stop bit (1 expected)
//    parity_type    in   2           00/11 none, 01 odd, 10 even
//    raw_data       in   DATA_WIDTH  received payload
//    error_flag     out  3           [0] parity, [1] start, [2] stop error
//    error_valid    out  1           error_flag was updated this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_error_check
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  recieved_flag,
   input  logic                  parity_bit,
   input  logic                  start_bit,
   input  logic                  stop_bit,
   input  logic [1:0]            parity_type,
   input  logic [DATA_WIDTH-1:0] raw_data,
   output logic [2:0]            error_flag,
   output logic                  error_valid
);

   logic                 expected_parity;
   logic                 parity_en;
   logic [ERR_WIDTH-1:0] next_flag;

   uart_parity_gen #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_parity_gen (
      .data        (raw_data),
      .parity_type (parity_type),
      .parity_out  (expected_parity),
      .parity_en   (parity_en)
   );

   // The three error conditions are independent of each other; a frame with
   // all three set is simply reported as such.
   always_comb begin
      next_flag             = '0;
      next_flag[ERR_PARITY] = parity_en & (parity_bit != expected_parity);
      next_flag[ERR_START]  = (start_bit != 1'b0);
      next_flag[ERR_STOP]   = (stop_bit != 1'b1);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         error_flag  <= 3'b000;
         error_valid <= 1'b0;
      end else if (recieved_flag) begin
         error_flag  <= next_flag;
         error_valid <= 1'b1;
      end else begin
         error_valid <= 1'b0;
      end
   end

endmodule : uart_rx_error_check
`default_nettype wire

// File: tb/tb_uart_rx_error_check.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_error_check
// Description : Self-checking bench for uart_rx_error_check. Directed frames
//               followed by randomized frames, strobe bursts and idle gaps,
//               all predicted by a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_error_check;

   localparam int DW = 8;

   logic          clock;
   logic          reset;
   logic          recieved_flag;
   logic          parity_bit;
   logic          start_bit;
   logic          stop_bit;
   logic [1:0]    parity_type;
   logic [DW-1:0] raw_data;
   logic [2:0]    error_flag;
   logic          error_valid;

   int compared   = 0;
   int mismatched = 0;

   // Model state: what the error vector should currently read
   logic [2:0] model_flag;

   uart_rx_error_check #(
      .DATA_WIDTH (DW)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .recieved_flag (recieved_flag),
      .parity_bit    (parity_bit),
      .start_bit     (start_bit),
      .stop_bit      (stop_bit),
      .parity_type   (parity_type),
      .raw_data      (raw_data),
      .error_flag    (error_flag),
      .error_valid   (error_valid)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Frame-level rules: count the ones in data plus parity and judge the
   // framing bits directly.
   function automatic logic [2:0] frame_errors(input logic s, input logic p_stop,
                                               input logic [1:0] mode, input logic pb,
                                               input logic [DW-1:0] d);
      int ones;
      logic par_err;
      ones = $countones(d) + int'(pb);
      case (mode)
         2'd1:    par_err = (ones % 2) == 0;   // odd: total ones must be odd
         2'd2:    par_err = (ones % 2) == 1;   // even: total ones must be even
         default: par_err = 1'b0;
      endcase
      return {p_stop != 1'b1, s != 1'b0, par_err};
   endfunction

   task automatic set_fields(input logic s, input logic p_stop, input logic [1:0] mode,
                             input logic pb, input logic [DW-1:0] d);
      start_bit   = s;
      stop_bit    = p_stop;
      parity_type = mode;
      parity_bit  = pb;
      raw_data    = d;
   endtask

   task automatic randomize_fields();
      set_fields(1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), DW'($urandom));
   endtask

   // Advance one clock with the current inputs, updating the model, then
   // compare once the registers have settled.
   task automatic step(input string tag);
      logic exp_valid;
      exp_valid = 1'b0;
      if (reset) begin
         model_flag = 3'b000;
      end else if (recieved_flag) begin
         model_flag = frame_errors(start_bit, stop_bit, parity_type, parity_bit, raw_data);
         exp_valid  = 1'b1;
      end
      @(posedge clock);
      #1;
      check({tag, "_flag"},  32'(error_flag),  32'(model_flag));
      check({tag, "_valid"}, 32'(error_valid), 32'(exp_valid));
   endtask

   initial begin
      model_flag    = 3'b000;
      reset         = 1'b1;
      recieved_flag = 1'b1;
      set_fields(1'b1, 1'b0, 2'b10, 1'b1, 8'hFF);

      // Reset wins over a simultaneous strobe
      step("reset0");
      step("reset1");
      reset = 1'b0;
      recieved_flag = 1'b0;
      step("post_reset_idle");

      // Even parity, good frame, then idle hold
      set_fields(1'b0, 1'b1, 2'b10, 1'b1, 8'h01);
      recieved_flag = 1'b1;
      step("even_ok");
      recieved_flag = 1'b0;
      step("even_hold");
      check("even_ok_const", 32'(error_flag), 32'h0);

      // Odd parity, bad then good
      set_fields(1'b0, 1'b1, 2'b01, 1'b1, 8'h01);
      recieved_flag = 1'b1;
      step("odd_bad");
      check("odd_bad_const", 32'(error_flag), 32'h1);
      set_fields(1'b0, 1'b1, 2'b01, 1'b0, 8'h01);
      step("odd_ok");

      // Framing errors without and with parity error
      set_fields(1'b1, 1'b0, 2'b00, 1'b0, 8'hA5);
      step("framing");
      check("framing_const", 32'(error_flag), 32'h6);
      set_fields(1'b1, 1'b0, 2'b10, 1'b1, 8'hA5);
      step("garbage");
      check("garbage_const", 32'(error_flag), 32'h7);

      // Strobe low: inputs churn but the vector holds
      recieved_flag = 1'b0;
      for (int i = 0; i < 5; i++) begin
         set_fields(1'b0, 1'b1, 2'b01, 1'($urandom), DW'($urandom));
         step("hold");
      end
      check("hold_const", 32'(error_flag), 32'h7);

      // Second no-parity encoding ignores parity_bit
      set_fields(1'b0, 1'b1, 2'b11, 1'b1, 8'h00);
      recieved_flag = 1'b1;
      step("none1");
      check("none1_const", 32'(error_flag), 32'h0);

      // Sweep every parity mode with random contents
      for (int m = 0; m < 4; m++) begin
         set_fields(1'($urandom), 1'($urandom), 2'(m), 1'($urandom), DW'($urandom));
         recieved_flag = 1'b1;
         step("sweep");
         recieved_flag = 1'b0;
         step("sweep_idle");
      end

      // Random bursts (strobe held several cycles) and idle gaps
      for (int n = 0; n < 60; n++) begin
         int burst;
         int gap;
         burst = int'($urandom_range(1, 3));
         gap   = int'($urandom_range(0, 2));
         recieved_flag = 1'b1;
         for (int b = 0; b < burst; b++) begin
            randomize_fields();
            step("rand_frame");
         end
         recieved_flag = 1'b0;
         for (int g = 0; g < gap; g++) begin
            randomize_fields();
            step("rand_gap");
         end
         if (n == 30) begin
            recieved_flag = 1'b1;
            set_fields(1'b1, 1'b0, 2'b10, 1'b0, 8'h01);
            reset = 1'b1;
            step("mid_reset");
            reset = 1'b0;
            recieved_flag = 1'b0;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule : tb_uart_rx_error_check
`default_nettype wire
